seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the team's hex-to-7-segment encoder: observes a time-multiplexed common-anode/cathode display bus (segment lines plus one-hot digit select) and recovers the displayed hex digits.
- Debounces each digit dwell, decodes the segment pattern back to a nibble, flags non-hex patterns, and publishes a full multi-digit frame once every digit position has been captured.
- Used in self-checking display paths and scan-bus loopback tests.

---
 rtl/seg7_scan_decoder_if.sv | 35 +++
 rtl/seg7_scan_decoder.sv | 211 +++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_decoder_if.sv
// Purpose : scan-bus bundle between a multiplexed 7-segment driver and seg7_scan_decoder.
// Latency : n/a (wires only).
// Backpressure : none; the scan bus is free-running and the decoder only observes it.
//
// Signals:
//   seg, dig_sel              - display scan bus (driven by the display side / master)
//   digit_valid/idx/nib/err   - per-digit capture strobe and payload (driven by the decoder / slave)
//   frame_valid/value/err_mask- published multi-digit frame (driven by the decoder / slave)
interface seg7_scan_decoder_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    digit_valid;
  logic [2:0]              digit_idx;
  logic [3:0]              digit_nib;
  logic                    digit_err;
  logic                    frame_valid;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   err_mask;

  // Display side: drives the scan lines, observes the recovered digits.
  modport master (
    output seg, dig_sel,
    input  digit_valid, digit_idx, digit_nib, digit_err,
    input  frame_valid, value, err_mask
  );

  // Decoder side: observes the scan lines, reports recovered digits and frames.
  modport slave (
    input  seg, dig_sel,
    output digit_valid, digit_idx, digit_nib, digit_err,
    output frame_valid, value, err_mask
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Purpose : recover hex digits from a time-multiplexed 7-segment scan bus and publish full frames.
// Latency : input registered once; digit_valid one cycle after the STABLE_CYCLES-th identical sample
//           is evaluated; frame_valid one cycle after the capture that completes the frame.
// Backpressure : none; outputs are single-cycle strobes, the observed bus cannot be stalled.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, clears all partial dwell/frame state
//   scan - slave side of seg7_scan_decoder_if:
//            seg[6:0] (a..g, bit6=a), dig_sel (one-hot while a digit is driven) in;
//            digit_valid/digit_idx/digit_nib/digit_err capture strobe out;
//            frame_valid/value/err_mask published frame out (digit i at value[4i+3:4i]).
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_decoder_if.slave scan
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam logic [NUM_DIGITS-1:0] SEL_ONE = NUM_DIGITS'(1);
  localparam logic [8:0]            RUN_TGT = 9'(STABLE_CYCLES);

  // Input stage and the previous sample used for run detection.
  logic [6:0]              seg_q, seg_prev_q;
  logic [NUM_DIGITS-1:0]   sel_q, sel_prev_q;

  // Dwell FSM.
  state_t                  state_q;
  logic [7:0]              run_q;

  // Frame assembly.
  logic [NUM_DIGITS-1:0]   cap_mask_q;
  logic [4*NUM_DIGITS-1:0] shadow_nib_q;
  logic [NUM_DIGITS-1:0]   shadow_err_q;
  logic                    pub_pend_q;

  // Registered outputs.
  logic                    digit_valid_q;
  logic [2:0]              digit_idx_q;
  logic [3:0]              digit_nib_q;
  logic                    digit_err_q;
  logic                    frame_valid_q;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   err_mask_q;

  // Combinational helpers.
  logic                    sel_onehot;
  logic                    same_sample;
  logic [8:0]              run_inc;
  logic                    capture_d;
  logic [NUM_DIGITS-1:0]   cap_mask_d;
  logic                    pub_pend_d;
  logic [2:0]              idx_enc;
  logic [3:0]              dec_nib;
  logic                    dec_err;

  // Glyph table; anything outside it is reported as an error with nibble 0.
  function automatic logic [4:0] decode_glyph(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h7E:   r = {1'b0, 4'h0};
      7'h30:   r = {1'b0, 4'h1};
      7'h6D:   r = {1'b0, 4'h2};
      7'h79:   r = {1'b0, 4'h3};
      7'h33:   r = {1'b0, 4'h4};
      7'h5B:   r = {1'b0, 4'h5};
      7'h5F:   r = {1'b0, 4'h6};
      7'h70:   r = {1'b0, 4'h7};
      7'h7F:   r = {1'b0, 4'h8};
      7'h73:   r = {1'b0, 4'h9};
      7'h77:   r = {1'b0, 4'hA};
      7'h1F:   r = {1'b0, 4'hB};
      7'h4E:   r = {1'b0, 4'hC};
      7'h3D:   r = {1'b0, 4'hD};
      7'h4F:   r = {1'b0, 4'hE};
      7'h47:   r = {1'b0, 4'hF};
      default: r = {1'b1, 4'h0};
    endcase
    return r;
  endfunction

  always_comb begin
    // Blanking (no bits) and ghosting overlap (several bits) are both "no digit driven".
    sel_onehot  = (sel_q != '0) && ((sel_q & (sel_q - SEL_ONE)) == '0);
    same_sample = (seg_q == seg_prev_q) && (sel_q == sel_prev_q);
    run_inc     = {1'b0, run_q} + 9'd1;

    // Only a SETTLE run can capture; HOLD suppresses re-capture of the same dwell.
    capture_d   = (state_q == SETTLE) && sel_onehot && same_sample && (run_inc == RUN_TGT);

    // The publish cycle clears the mask, but a capture landing in it starts the next frame.
    cap_mask_d  = pub_pend_q ? '0 : cap_mask_q;
    if (capture_d) begin
      cap_mask_d = cap_mask_d | sel_q;
    end
    pub_pend_d  = capture_d && (&cap_mask_d);

    idx_enc = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_q[i]) begin
        idx_enc = 3'(i);
      end
    end

    {dec_err, dec_nib} = decode_glyph(seg_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q         <= '0;
      sel_q         <= '0;
      seg_prev_q    <= '0;
      sel_prev_q    <= '0;
      state_q       <= IDLE;
      run_q         <= '0;
      cap_mask_q    <= '0;
      shadow_nib_q  <= '0;
      shadow_err_q  <= '0;
      pub_pend_q    <= 1'b0;
      digit_valid_q <= 1'b0;
      digit_idx_q   <= '0;
      digit_nib_q   <= '0;
      digit_err_q   <= 1'b0;
      frame_valid_q <= 1'b0;
      value_q       <= '0;
      err_mask_q    <= '0;
    end else begin
      seg_q      <= scan.seg;
      sel_q      <= scan.dig_sel;
      seg_prev_q <= seg_q;
      sel_prev_q <= sel_q;

      case (state_q)
        IDLE: begin
          if (sel_onehot) begin
            state_q <= SETTLE;
            run_q   <= 8'd1;
          end else begin
            run_q   <= '0;
          end
        end
        SETTLE: begin
          if (!sel_onehot) begin
            state_q <= IDLE;
            run_q   <= '0;
          end else if (!same_sample) begin
            run_q   <= 8'd1;
          end else begin
            run_q   <= run_inc[7:0];
            if (capture_d) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!sel_onehot) begin
            state_q <= IDLE;
            run_q   <= '0;
          end else if (!same_sample) begin
            state_q <= SETTLE;
            run_q   <= 8'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          run_q   <= '0;
        end
      endcase

      digit_valid_q <= capture_d;
      if (capture_d) begin
        digit_idx_q <= idx_enc;
        digit_nib_q <= dec_nib;
        digit_err_q <= dec_err;
        // Re-capturing an index simply overwrites its slot.
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel_q[i]) begin
            shadow_nib_q[4*i +: 4] <= dec_nib;
            shadow_err_q[i]        <= dec_err;
          end
        end
      end

      cap_mask_q    <= cap_mask_d;
      pub_pend_q    <= pub_pend_d;
      frame_valid_q <= pub_pend_q;
      // Shadow still holds the completed frame here: a same-cycle capture only lands after this edge.
      if (pub_pend_q) begin
        value_q    <= shadow_nib_q;
        err_mask_q <= shadow_err_q;
      end
    end
  end

  assign scan.digit_valid = digit_valid_q;
  assign scan.digit_idx   = digit_idx_q;
  assign scan.digit_nib   = digit_nib_q;
  assign scan.digit_err   = digit_err_q;
  assign scan.frame_valid = frame_valid_q;
  assign scan.value       = value_q;
  assign scan.err_mask    = err_mask_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Purpose : bench for seg7_scan_decoder: directed scenarios plus random dwells against a dwell-level model.
// Latency : model expects digit_valid STABLE_CYCLES+1 edges after a dwell's first edge, frame one cycle later.
// Backpressure : none; the bench drives the scan bus freely.
module tb_seg7_scan_decoder;
  localparam int ND = 4;
  localparam int S  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk  (clk),
    .rst  (rst),
    .scan (bus)
  );

  typedef struct {
    int         due;
    logic [2:0] idx;
    logic [3:0] nib;
    logic       err;
  } dev_t;

  typedef struct {
    int              due;
    logic [4*ND-1:0] val;
    logic [ND-1:0]   em;
  } fev_t;

  dev_t dq[$];
  fev_t fq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [6:0] glyph [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Model of the frame being assembled and the last published frame.
  logic [3:0]      m_nib [ND];
  logic            m_err [ND];
  bit              m_cap [ND];
  logic [4*ND-1:0] pub_val;
  logic [ND-1:0]   pub_em;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    dq.delete();
    fq.delete();
    for (int i = 0; i < ND; i++) begin
      m_nib[i] = 4'h0;
      m_err[i] = 1'b0;
      m_cap[i] = 1'b0;
    end
    pub_val = '0;
    pub_em  = '0;
  endtask

  // One clock: advance, then compare every output with the model on the falling edge.
  task automatic tick();
    bit              efv, edv, all;
    logic [4*ND-1:0] v;
    logic [ND-1:0]   e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    efv = (fq.size() > 0) && (fq[0].due == cyc);
    if (efv) begin
      pub_val = fq[0].val;
      pub_em  = fq[0].em;
      void'(fq.pop_front());
    end
    chk("frame_valid", 32'(bus.frame_valid), 32'(efv));
    chk("value", 32'(bus.value), 32'(pub_val));
    chk("err_mask", 32'(bus.err_mask), 32'(pub_em));
    edv = (dq.size() > 0) && (dq[0].due == cyc);
    chk("digit_valid", 32'(bus.digit_valid), 32'(edv));
    if (edv) begin
      chk("digit_idx", 32'(bus.digit_idx), 32'(dq[0].idx));
      chk("digit_nib", 32'(bus.digit_nib), 32'(dq[0].nib));
      chk("digit_err", 32'(bus.digit_err), 32'(dq[0].err));
      m_nib[dq[0].idx] = dq[0].nib;
      m_err[dq[0].idx] = dq[0].err;
      m_cap[dq[0].idx] = 1'b1;
      void'(dq.pop_front());
      all = 1'b1;
      for (int i = 0; i < ND; i++) all &= m_cap[i];
      if (all) begin
        for (int i = 0; i < ND; i++) begin
          v[4*i +: 4] = m_nib[i];
          e[i]        = m_err[i];
          m_cap[i]    = 1'b0;
        end
        fq.push_back('{due: cyc + 1, val: v, em: e});
      end
    end
    if (dq.size() > 0 && dq[0].due < cyc) begin
      chk("digit_overdue", 32'(dq[0].due), 32'(cyc));
      void'(dq.pop_front());
    end
  endtask

  // Hold one scan pattern for len cycles; consecutive dwells must differ to stay separate.
  task automatic dwell(input logic [ND-1:0] sel, input logic [6:0] sg, input int len);
    dev_t d;
    bit   hit;
    bus.dig_sel = sel;
    bus.seg     = sg;
    if ($countones(sel) == 1 && len >= S) begin
      d.due = cyc + 1 + S;
      d.idx = '0;
      for (int i = 0; i < ND; i++) if (sel[i]) d.idx = 3'(i);
      d.nib = 4'h0;
      d.err = 1'b1;
      hit   = 1'b0;
      for (int j = 0; j < 16; j++) begin
        if (!hit && glyph[j] == sg) begin
          d.nib = 4'(j);
          d.err = 1'b0;
          hit   = 1'b1;
        end
      end
      dq.push_back(d);
    end
    repeat (len) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    model_clear();
    repeat (n) tick();
    chk("rst_digit_valid", 32'(bus.digit_valid), 32'd0);
    chk("rst_digit_idx", 32'(bus.digit_idx), 32'd0);
    chk("rst_digit_nib", 32'(bus.digit_nib), 32'd0);
    chk("rst_digit_err", 32'(bus.digit_err), 32'd0);
    chk("rst_value", 32'(bus.value), 32'd0);
    chk("rst_err_mask", 32'(bus.err_mask), 32'd0);
    bus.dig_sel = '0;
    bus.seg     = '0;
    rst = 1'b0;
  endtask

  initial begin
    logic [ND-1:0] rs, last_sel;
    logic [6:0]    rg, last_seg;
    int            kind, b0, b1;

    rst         = 1'b1;
    bus.dig_sel = '0;
    bus.seg     = '0;
    model_clear();
    @(negedge clk);
    do_reset(2);

    // Nominal scan 1,2,3,4.
    dwell(4'b0001, 7'h30, 8);
    dwell(4'b0010, 7'h6D, 8);
    dwell(4'b0100, 7'h79, 8);
    dwell(4'b1000, 7'h33, 8);
    chk("nominal_value", 32'(bus.value), 32'h4321);
    chk("nominal_err_mask", 32'(bus.err_mask), 32'h0);

    // Glitch rejection: 3-cycle dwell ignored, 4-cycle dwell captured once.
    dwell(4'b0001, 7'h7E, 3);
    dwell(4'b0000, 7'h00, 2);
    dwell(4'b0001, 7'h7E, 4);
    dwell(4'b0000, 7'h00, 2);

    // Invalid glyph on digit 2.
    dwell(4'b0001, 7'h7E, 8);
    dwell(4'b0010, 7'h30, 8);
    dwell(4'b0100, 7'h01, 8);
    dwell(4'b1000, 7'h6D, 8);
    chk("invalid_value", 32'(bus.value), 32'h2010);
    chk("invalid_err_mask", 32'(bus.err_mask), 32'b0100);

    // Blanking and overlap between dwells.
    dwell(4'b0001, 7'h30, 5);
    dwell(4'b0000, 7'h00, 3);
    dwell(4'b0011, 7'h30, 3);
    dwell(4'b0010, 7'h6D, 6);
    dwell(4'b0011, 7'h6D, 6);
    dwell(4'b0100, 7'h79, 6);

    // Overwrite: digit 0 as A then F before the frame completes.
    dwell(4'b0001, 7'h77, 6);
    dwell(4'b0000, 7'h00, 2);
    dwell(4'b0001, 7'h47, 6);
    dwell(4'b0010, 7'h30, 6);
    dwell(4'b0100, 7'h30, 6);
    dwell(4'b1000, 7'h30, 6);
    chk("overwrite_value", 32'(bus.value), 32'h111F);

    // Reset mid-dwell, then a fresh frame with no stale digits.
    dwell(4'b0001, 7'h7F, 2);
    do_reset(2);
    dwell(4'b0001, 7'h5B, 8);
    dwell(4'b0010, 7'h5F, 8);
    dwell(4'b0100, 7'h70, 8);
    dwell(4'b1000, 7'h7F, 8);
    chk("post_reset_value", 32'(bus.value), 32'h8765);
    chk("post_reset_err_mask", 32'(bus.err_mask), 32'h0);

    // Random dwells: blanking, overlap, legal and illegal glyphs, short and long dwells.
    last_sel = 4'b1000;
    last_seg = 7'h7F;
    for (int k = 0; k < 200; k++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        rs = '0;
      end else if (kind == 1) begin
        b0 = int'($urandom_range(0, ND - 1));
        b1 = (b0 + int'($urandom_range(1, ND - 1))) % ND;
        rs = '0;
        rs[b0] = 1'b1;
        rs[b1] = 1'b1;
      end else begin
        rs = '0;
        rs[$urandom_range(0, ND - 1)] = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) rg = 7'($urandom_range(0, 127));
      else                           rg = glyph[$urandom_range(0, 15)];
      if (rs == last_sel && rg == last_seg) rg = rg ^ 7'h01;
      dwell(rs, rg, int'($urandom_range(1, 9)));
      last_sel = rs;
      last_seg = rg;
    end

    dwell(4'b0000, 7'h00, 12);
    chk("expectations_drained", 32'(dq.size() + fq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on run length.
  initial begin
    #500000;
    $display("FAIL timeout cycles=%0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
